// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller.
//   state_t          : FSM state codes, also driven out on the phase port
//   LAMP_*           : two-bit lamp encodings (00 red, 01 yellow, 10 green)
//   DEFAULT_*        : default timing durations in clock cycles
//   next_phase()     : fixed cyclic successor of each state
//   ns_lamp/ew_lamp(): lamp decode for each direction
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    localparam int DEFAULT_TIMER_WIDTH  = 6;
    localparam int DEFAULT_GREEN_MIN    = 10;
    localparam int DEFAULT_GREEN_MAX    = 31;
    localparam int DEFAULT_YELLOW_TIME  = 4;
    localparam int DEFAULT_ALL_RED_TIME = 2;

    function automatic state_t next_phase(input state_t s);
        case (s)
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return ALL_RED_A;
            ALL_RED_A: return EW_GREEN;
            EW_GREEN:  return EW_YELLOW;
            EW_YELLOW: return ALL_RED_B;
            ALL_RED_B: return NS_GREEN;
            default:   return NS_GREEN;
        endcase
    endfunction

    function automatic logic [1:0] ns_lamp(input state_t s);
        case (s)
            NS_GREEN:  return LAMP_GREEN;
            NS_YELLOW: return LAMP_YELLOW;
            default:   return LAMP_RED;
        endcase
    endfunction

    function automatic logic [1:0] ew_lamp(input state_t s);
        case (s)
            EW_GREEN:  return LAMP_GREEN;
            EW_YELLOW: return LAMP_YELLOW;
            default:   return LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/saturation_timer.sv
// Down-counter that saturates at zero.
//   clk, reset  : clock and asynchronous active-high reset (loads RESET_VALUE)
//   load        : load load_value on the next edge (wins over decrement)
//   load_value  : value to load
//   dec_en      : decrement by one per edge, holding at zero
//   count       : current count
//   is_zero     : count equals zero
module saturation_timer #(
    parameter int               WIDTH       = 6,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec_en,
    output logic [WIDTH-1:0] count,
    output logic             is_zero
);

    logic [WIDTH-1:0] count_r;

    // Countdown register: load first, otherwise decrement and stick at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= RESET_VALUE;
        end else if (load) begin
            count_r <= load_value;
        end else if (dec_en && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count   = count_r;
    assign is_zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/traffic_light_controller.sv
// Two-way intersection controller with demand-driven green extension.
//   clk, reset            : clock and asynchronous active-high reset
//   ns_car, ew_car        : vehicle sensors, sampled every rising edge
//   ns_light, ew_light    : lamp outputs (00 red, 01 yellow, 10 green)
//   phase                 : current state code
//   current_count         : remaining cycles minus one in the timed interval
//   ns_pending, ew_pending: latched service requests
module traffic_light_controller
    import traffic_pkg::*;
#(
    parameter int TIMER_WIDTH  = DEFAULT_TIMER_WIDTH,
    parameter int GREEN_MIN    = DEFAULT_GREEN_MIN,
    parameter int GREEN_MAX    = DEFAULT_GREEN_MAX,
    parameter int YELLOW_TIME  = DEFAULT_YELLOW_TIME,
    parameter int ALL_RED_TIME = DEFAULT_ALL_RED_TIME
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ns_car,
    input  logic                   ew_car,
    output logic [1:0]             ns_light,
    output logic [1:0]             ew_light,
    output logic [2:0]             phase,
    output logic [TIMER_WIDTH-1:0] current_count,
    output logic                   ns_pending,
    output logic                   ew_pending
);

    localparam longint TIMER_SPAN = longint'(1) << TIMER_WIDTH;

    if (TIMER_WIDTH < 1 || TIMER_WIDTH > 30 ||
        GREEN_MIN < 1 || GREEN_MIN > TIMER_SPAN ||
        GREEN_MAX < 1 || GREEN_MAX > TIMER_SPAN ||
        YELLOW_TIME < 1 || YELLOW_TIME > TIMER_SPAN ||
        ALL_RED_TIME < 1 || ALL_RED_TIME > TIMER_SPAN ||
        GREEN_MAX < GREEN_MIN) begin : g_bad_params
        $error("traffic_light_controller: invalid timing parameters");
    end

    localparam logic [TIMER_WIDTH-1:0] GREEN_LOAD   = TIMER_WIDTH'(GREEN_MIN - 1);
    localparam logic [TIMER_WIDTH-1:0] YELLOW_LOAD  = TIMER_WIDTH'(YELLOW_TIME - 1);
    localparam logic [TIMER_WIDTH-1:0] ALL_RED_LOAD = TIMER_WIDTH'(ALL_RED_TIME - 1);
    // Extra green granted once; only meaningful when GREEN_MAX > GREEN_MIN.
    localparam logic [TIMER_WIDTH-1:0] EXTEND_LOAD  = TIMER_WIDTH'(GREEN_MAX - GREEN_MIN - 1);
    localparam logic                   CAN_EXTEND   = (GREEN_MAX > GREEN_MIN) ? 1'b1 : 1'b0;

    function automatic logic [TIMER_WIDTH-1:0] duration_load(input state_t s);
        case (s)
            NS_YELLOW, EW_YELLOW: return YELLOW_LOAD;
            ALL_RED_A, ALL_RED_B: return ALL_RED_LOAD;
            default:              return GREEN_LOAD;
        endcase
    endfunction

    state_t                   state_r;
    logic                     extend_r;
    logic                     ns_pending_r;
    logic                     ew_pending_r;
    state_t                   next_state_s;
    logic                     set_extend_s;
    logic                     entering_s;
    logic                     cross_pending_s;
    logic                     own_car_s;
    logic                     timer_load_s;
    logic [TIMER_WIDTH-1:0]   timer_load_value_s;
    logic [TIMER_WIDTH-1:0]   count_s;
    logic                     count_zero_s;

    // Seen from whichever green is active; unused outside green states.
    assign cross_pending_s = (state_r == NS_GREEN) ? ew_pending_r : ns_pending_r;
    assign own_car_s       = (state_r == NS_GREEN) ? ns_car : ew_car;

    // Next-state and extension decision from the current state and countdown.
    always_comb begin
        next_state_s = state_r;
        set_extend_s = 1'b0;
        case (state_r)
            NS_GREEN, EW_GREEN: begin
                if (!count_zero_s) begin
                    next_state_s = state_r;
                end else if (extend_r) begin
                    next_state_s = next_phase(state_r);
                end else if (cross_pending_s && own_car_s && CAN_EXTEND) begin
                    set_extend_s = 1'b1;
                end else if (cross_pending_s) begin
                    next_state_s = next_phase(state_r);
                end else begin
                    next_state_s = state_r;
                end
            end
            NS_YELLOW, ALL_RED_A, EW_YELLOW, ALL_RED_B: begin
                if (count_zero_s) begin
                    next_state_s = next_phase(state_r);
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = NS_GREEN;
            end
        endcase
    end

    assign entering_s         = (next_state_s != state_r);
    assign timer_load_s       = entering_s | set_extend_s;
    assign timer_load_value_s = entering_s ? duration_load(next_state_s) : EXTEND_LOAD;

    saturation_timer #(
        .WIDTH       (TIMER_WIDTH),
        .RESET_VALUE (GREEN_LOAD)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load_s),
        .load_value (timer_load_value_s),
        .dec_en     (1'b1),
        .count      (count_s),
        .is_zero    (count_zero_s)
    );

    // State, extend flag and request latches; entry into a green clears its
    // own request even if the sensor is asserted on that same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= NS_GREEN;
            extend_r     <= 1'b0;
            ns_pending_r <= 1'b0;
            ew_pending_r <= 1'b0;
        end else begin
            state_r <= next_state_s;

            if (entering_s) begin
                extend_r <= 1'b0;
            end else if (set_extend_s) begin
                extend_r <= 1'b1;
            end else begin
                extend_r <= extend_r;
            end

            if (entering_s && (next_state_s == NS_GREEN)) begin
                ns_pending_r <= 1'b0;
            end else if (ns_car && (state_r != NS_GREEN)) begin
                ns_pending_r <= 1'b1;
            end else begin
                ns_pending_r <= ns_pending_r;
            end

            if (entering_s && (next_state_s == EW_GREEN)) begin
                ew_pending_r <= 1'b0;
            end else if (ew_car && (state_r != EW_GREEN)) begin
                ew_pending_r <= 1'b1;
            end else begin
                ew_pending_r <= ew_pending_r;
            end
        end
    end

    assign ns_light      = ns_lamp(state_r);
    assign ew_light      = ew_lamp(state_r);
    assign phase         = state_r;
    assign current_count = count_s;
    assign ns_pending    = ns_pending_r;
    assign ew_pending    = ew_pending_r;

endmodule
